alu_seq_ctrl: RTL and testbench

Multi-pass sequencer that owns the shared 32-bit ALU datapath and executes 64-bit (two-pass) or 32-bit (single-pass) operations.
- Accepts requests on a valid/ready handshake, drives ALU op, operand and carry-in lines each pass, and chains the carry between passes.
- Merges per-pass NZCV into 64-bit flags, keeps a persistent flags register, and returns the result on a valid/ready response channel.
- Sits between the execute-stage issue logic and the combinational ALU.

---
 rtl/alu_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-pass sequencer that drives a shared 32-bit ALU for 64-bit and 32-bit ops.
// Chains carry between passes and merges per-pass flags into 64-bit NZCV.
module alu_seq_ctrl #(
    parameter int DW     = 32,
    parameter int ADD_OP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_wide,
    input  logic            req_setf,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [2*DW-1:0] resp_result,
    output logic [3:0]      resp_nzcv,
    output logic [3:0]      flags_q,
    output logic [3:0]      alu_op,
    output logic [DW-1:0]   alu_src1,
    output logic [DW-1:0]   alu_src2,
    output logic            alu_c_in,
    input  logic [DW-1:0]   alu_out,
    input  logic [3:0]      alu_nzcv
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ORR = 3'd4;
    localparam logic [2:0] OP_ADC = 3'd5;
    localparam logic [2:0] OP_SBC = 3'd6;
    localparam logic [2:0] OP_BIC = 3'd7;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_XOR = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'(ADD_OP);
    localparam logic [3:0] ALU_ADC = 4'(ADD_OP + 1);
    localparam logic [3:0] ALU_SBC = 4'd6;
    localparam logic [3:0] ALU_ORR = 4'd12;
    localparam logic [3:0] ALU_BIC = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              wide_q, wide_d;
    logic              setf_q, setf_d;
    logic [2*DW-1:0]   a_q, a_d;
    logic [2*DW-1:0]   b_q, b_d;
    logic [2*DW-1:0]   res_q, res_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic [3:0]        flags_d;
    logic              c_lo_q, c_lo_d;
    logic              z_lo_q, z_lo_d;

    logic [3:0]        lo_code;
    logic [3:0]        hi_code;
    logic              lo_cin;

    // Carry-using ops take their LO-pass carry from the persistent flags.
    always_comb begin
        lo_code = ALU_AND;
        hi_code = ALU_AND;
        lo_cin  = 1'b0;
        unique case (op_q)
            OP_ADD: begin lo_code = ALU_ADD; hi_code = ALU_ADC; end
            OP_SUB: begin lo_code = ALU_SUB; hi_code = ALU_SBC; end
            OP_AND: begin lo_code = ALU_AND; hi_code = ALU_AND; end
            OP_XOR: begin lo_code = ALU_XOR; hi_code = ALU_XOR; end
            OP_ORR: begin lo_code = ALU_ORR; hi_code = ALU_ORR; end
            OP_ADC: begin
                lo_code = ALU_ADC;
                hi_code = ALU_ADC;
                lo_cin  = flags_q[1];
            end
            OP_SBC: begin
                lo_code = ALU_SBC;
                hi_code = ALU_SBC;
                lo_cin  = flags_q[1];
            end
            OP_BIC: begin lo_code = ALU_BIC; hi_code = ALU_BIC; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wide_d   = wide_q;
        setf_d   = setf_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        nzcv_d   = nzcv_q;
        flags_d  = flags_q;
        c_lo_d   = c_lo_q;
        z_lo_d   = z_lo_q;
        alu_op   = 4'd0;
        alu_src1 = '0;
        alu_src2 = '0;
        alu_c_in = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    wide_d  = req_wide;
                    setf_d  = req_setf;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                alu_op   = lo_code;
                alu_src1 = a_q[DW-1:0];
                alu_src2 = b_q[DW-1:0];
                alu_c_in = lo_cin;
                res_d    = {{DW{1'b0}}, alu_out};
                c_lo_d   = alu_nzcv[1];
                z_lo_d   = alu_nzcv[2];
                if (wide_q) begin
                    state_d = S_HI;
                end else begin
                    nzcv_d  = alu_nzcv;
                    if (setf_q) flags_d = alu_nzcv;
                    state_d = S_DONE;
                end
            end
            S_HI: begin
                alu_op   = hi_code;
                alu_src1 = a_q[2*DW-1:DW];
                alu_src2 = b_q[2*DW-1:DW];
                alu_c_in = c_lo_q;
                res_d    = {alu_out, res_q[DW-1:0]};
                // 64-bit zero needs both halves zero.
                nzcv_d   = {alu_nzcv[3], z_lo_q & alu_nzcv[2], alu_nzcv[1:0]};
                if (setf_q) flags_d = nzcv_d;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wide_q  <= 1'b0;
            setf_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            nzcv_q  <= '0;
            flags_q <= '0;
            c_lo_q  <= 1'b0;
            z_lo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wide_q  <= wide_d;
            setf_q  <= setf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            nzcv_q  <= nzcv_d;
            flags_q <= flags_d;
            c_lo_q  <= c_lo_d;
            z_lo_q  <= z_lo_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign resp_result = res_q;
    assign resp_nzcv   = nzcv_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 32-bit ALU plus directed vector table
// and hand-written sequences for response stall and mid-op reset.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_wide;
    logic        req_setf;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic [3:0]  resp_nzcv;
    logic [3:0]  flags_q;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        alu_c_in;
    logic [31:0] alu_out;
    logic [3:0]  alu_nzcv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DW(32), .ADD_OP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wide(req_wide), .req_setf(req_setf),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_nzcv(resp_nzcv),
        .flags_q(flags_q),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_c_in(alu_c_in), .alu_out(alu_out), .alu_nzcv(alu_nzcv)
    );

    // Behavioural ALU: C is carry-out (no-borrow for subtracts).
    logic [32:0] m_sum;
    logic [31:0] m_be;
    logic [31:0] m_log;
    logic        m_ci;
    logic        m_add;
    always_comb begin
        m_add = 1'b1;
        m_be  = alu_src2;
        m_ci  = 1'b0;
        m_log = '0;
        case (alu_op)
            4'd0:  begin m_add = 1'b0; m_log = alu_src1 & alu_src2; end
            4'd1:  begin m_add = 1'b0; m_log = alu_src1 ^ alu_src2; end
            4'd12: begin m_add = 1'b0; m_log = alu_src1 | alu_src2; end
            4'd14: begin m_add = 1'b0; m_log = alu_src1 & ~alu_src2; end
            4'd2:  begin m_be = ~alu_src2; m_ci = 1'b1; end
            4'd4:  m_ci = 1'b0;
            4'd5:  m_ci = alu_c_in;
            4'd6:  begin m_be = ~alu_src2; m_ci = alu_c_in; end
            default: m_add = 1'b0;
        endcase
        m_sum = {1'b0, alu_src1} + {1'b0, m_be} + {32'd0, m_ci};
        if (m_add) begin
            alu_out  = m_sum[31:0];
            alu_nzcv = {m_sum[31], m_sum[31:0] == 32'd0, m_sum[32],
                        (alu_src1[31] == m_be[31]) && (m_sum[31] != alu_src1[31])};
        end else begin
            alu_out  = m_log;
            alu_nzcv = {m_log[31], m_log == 32'd0, 2'b00};
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic        wide;
        logic        setf;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  nzcv;
        logic [3:0]  flags;
        int          lat;
        logic [3:0]  op_lo;
        logic [3:0]  op_hi;
        logic        cin_lo;
        logic        cin_hi;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int          lat;
        logic [3:0]  op_lo, op_hi;
        logic        cin_lo, cin_hi;
        req_op    = v.op;
        req_wide  = v.wide;
        req_setf  = v.setf;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        check($sformatf("v%0d req_ready", idx), 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_op    = 3'($urandom);
        lat    = 1;
        op_lo  = alu_op;
        cin_lo = alu_c_in;
        op_hi  = 4'd0;
        cin_hi = 1'b0;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2 && !resp_valid) begin
                op_hi  = alu_op;
                cin_hi = alu_c_in;
            end
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d result", idx), resp_result, v.res);
        check($sformatf("v%0d nzcv", idx), 64'(resp_nzcv), 64'(v.nzcv));
        check($sformatf("v%0d flags", idx), 64'(flags_q), 64'(v.flags));
        check($sformatf("v%0d op_lo", idx), 64'(op_lo), 64'(v.op_lo));
        check($sformatf("v%0d cin_lo", idx), 64'(cin_lo), 64'(v.cin_lo));
        if (v.wide) begin
            check($sformatf("v%0d op_hi", idx), 64'(op_hi), 64'(v.op_hi));
            check($sformatf("v%0d cin_hi", idx), 64'(cin_hi), 64'(v.cin_hi));
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d resp_clr", idx), 64'(resp_valid), 64'd0);
    endtask

    logic [63:0] held_res;
    logic [3:0]  held_nzcv;
    int          w;

    initial begin
        //           op    w     s     a                       b                       res                     nzcv  flg   lat lo     hi     cl    ch
        vecs[0]  = '{3'd0, 1'b1, 1'b0, 64'h00000000_FFFFFFFF, 64'd1,                  64'h00000001_00000000, 4'h0, 4'h0, 3, 4'd4,  4'd5,  1'b0, 1'b1};
        vecs[1]  = '{3'd1, 1'b1, 1'b0, 64'd0,                  64'd1,                  64'hFFFFFFFF_FFFFFFFF, 4'h8, 4'h0, 3, 4'd2,  4'd6,  1'b0, 1'b0};
        vecs[2]  = '{3'd1, 1'b1, 1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'd0,                  4'h6, 4'h6, 3, 4'd2,  4'd6,  1'b0, 1'b1};
        vecs[3]  = '{3'd0, 1'b1, 1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'd1,                  64'h80000000_00000000, 4'h9, 4'h6, 3, 4'd4,  4'd5,  1'b0, 1'b1};
        vecs[4]  = '{3'd5, 1'b0, 1'b0, 64'd1,                  64'd1,                  64'd3,                  4'h0, 4'h6, 2, 4'd5,  4'd0,  1'b1, 1'b0};
        vecs[5]  = '{3'd2, 1'b0, 1'b1, 64'hFFFFFFFF_F0F0F0F0, 64'h0000FFFF_FF00FF00, 64'h00000000_F000F000, 4'h8, 4'h8, 2, 4'd0,  4'd0,  1'b0, 1'b0};
        vecs[6]  = '{3'd3, 1'b0, 1'b1, 64'h12345678,           64'h12345678,           64'd0,                  4'h4, 4'h4, 2, 4'd1,  4'd0,  1'b0, 1'b0};
        vecs[7]  = '{3'd4, 1'b0, 1'b0, 64'h0F,                 64'h30,                 64'h3F,                 4'h0, 4'h4, 2, 4'd12, 4'd0,  1'b0, 1'b0};
        vecs[8]  = '{3'd7, 1'b0, 1'b0, 64'hFF,                 64'h0F,                 64'hF0,                 4'h0, 4'h4, 2, 4'd14, 4'd0,  1'b0, 1'b0};
        vecs[9]  = '{3'd6, 1'b0, 1'b1, 64'd5,                  64'd3,                  64'd1,                  4'h2, 4'h2, 2, 4'd6,  4'd0,  1'b0, 1'b0};
        vecs[10] = '{3'd5, 1'b1, 1'b0, 64'h00000000_FFFFFFFF, 64'd0,                  64'h00000001_00000000, 4'h0, 4'h2, 3, 4'd5,  4'd5,  1'b1, 1'b1};
        vecs[11] = '{3'd1, 1'b0, 1'b1, 64'd3,                  64'd5,                  64'h00000000_FFFFFFFE, 4'h8, 4'h8, 2, 4'd2,  4'd0,  1'b0, 1'b0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_wide   = 1'b0;
        req_setf   = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #2;
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst result", resp_result, 64'd0);
        check("rst nzcv", 64'(resp_nzcv), 64'd0);
        check("rst flags", 64'(flags_q), 64'd0);
        check("rst alu", {27'd0, alu_op, alu_c_in, alu_src1}, 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_op(vecs[i], i);

        // Stalled response: outputs hold, stray request is ignored.
        resp_ready = 1'b0;
        req_op    = 3'd0;
        req_wide  = 1'b1;
        req_setf  = 1'b0;
        req_a     = 64'd1;
        req_b     = 64'd2;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_op    = 3'd1;
        req_setf  = 1'b1;
        req_a     = 64'd7;
        req_b     = 64'd7;
        w = 0;
        while (!resp_valid && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("stall reach done", 64'(resp_valid), 64'd1);
        held_res  = resp_result;
        held_nzcv = resp_nzcv;
        check("stall result", held_res, 64'd3);
        check("stall nzcv", 64'(held_nzcv), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d valid", k), 64'(resp_valid), 64'd1);
            check($sformatf("stall%0d ready", k), 64'(req_ready), 64'd0);
            check($sformatf("stall%0d result", k), resp_result, 64'd3);
            check($sformatf("stall%0d nzcv", k), 64'(resp_nzcv), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall release", 64'(resp_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stray ignored valid", 64'(resp_valid), 64'd0);
        check("stray ignored flags", 64'(flags_q), 64'd8);

        // Reset during the HI pass of a wide op.
        req_op    = 3'd0;
        req_wide  = 1'b1;
        req_setf  = 1'b1;
        req_a     = 64'h00000005_00000005;
        req_b     = 64'h00000003_00000003;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hi pass op", 64'(alu_op), 64'd5);
        check("hi pass src1", 64'(alu_src1), 64'd5);
        rst_n = 1'b0;
        #1;
        check("mid rst req_ready", 64'(req_ready), 64'd1);
        check("mid rst resp_valid", 64'(resp_valid), 64'd0);
        check("mid rst result", resp_result, 64'd0);
        check("mid rst nzcv", 64'(resp_nzcv), 64'd0);
        check("mid rst flags", 64'(flags_q), 64'd0);
        check("mid rst alu", {27'd0, alu_op, alu_c_in, alu_src1}, 64'd0);
        check("mid rst src2", 64'(alu_src2), 64'd0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post rst%0d valid", k), 64'(resp_valid), 64'd0);
        end
        check("post rst flags", 64'(flags_q), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
